// File: rtl/tone_oscillator_if.sv
// Tone oscillator control/output bundle: note controls in, tone outputs back.
interface tone_oscillator_if #(parameter int SAMPLE_W = 8);
  logic                en;
  logic [15:0]         divider;
  logic [1:0]          wave_sel;
  logic                square_out;
  logic [SAMPLE_W-1:0] sample;
  logic                period_start;

  modport master (output en, divider, wave_sel,
                  input  square_out, sample, period_start);
  modport slave  (input  en, divider, wave_sel,
                  output square_out, sample, period_start);
endinterface

// File: rtl/tone_oscillator.sv
// Period-driven tone generator: square pin output plus 8-bit square/saw/triangle sample.
module tone_oscillator #(
  parameter int SAMPLE_W = 8
) (
  input  logic               clk,
  input  logic               nrst,
  tone_oscillator_if.slave   bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [15:0] count, active_div;
  logic [7:0]  step_cnt, phase, step_len, tri_val;
  logic        go, run, wrap;

  assign go       = bus.en && (bus.divider > 16'd1);
  assign run      = (state == RUN);
  assign wrap     = (count == active_div - 16'd1);
  assign step_len = (active_div[15:8] == 8'd0) ? 8'd1 : active_div[15:8];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      count      <= '0;
      step_cnt   <= '0;
      phase      <= '0;
      active_div <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state      <= RUN;
          active_div <= bus.divider;
          count      <= '0;
          step_cnt   <= '0;
          phase      <= '0;
        end
        RUN: begin
          if (!go) begin
            // immediate mute, does not wait for the period to finish
            state      <= IDLE;
            count      <= '0;
            step_cnt   <= '0;
            phase      <= '0;
            active_div <= '0;
          end else if (wrap) begin
            count      <= '0;
            step_cnt   <= '0;
            phase      <= '0;
            active_div <= bus.divider;
          end else begin
            count <= count + 16'd1;
            if (step_cnt == step_len - 8'd1) begin
              step_cnt <= '0;
              if (phase != 8'hFF) phase <= phase + 8'd1;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.square_out   = run && (count < {1'b0, active_div[15:1]});
  assign bus.period_start = run && (count == 16'd0);
  assign tri_val          = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};

  // wave_sel steers the mux directly so a waveform change is seen the same cycle
  always_comb begin
    bus.sample = '0;
    if (run) begin
      case (bus.wave_sel)
        2'b01:   bus.sample = phase;
        2'b10:   bus.sample = tri_val;
        default: bus.sample = bus.square_out ? 8'hFF : 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_oscillator.sv
// Randomized scoreboard bench for tone_oscillator against a period-position reference model.
module tb_tone_oscillator;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  tone_oscillator_if #(.SAMPLE_W(8)) bus();
  tone_oscillator #(.SAMPLE_W(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  typedef struct {
    logic       sq;
    logic [7:0] smp;
    logic       ps;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   m_run = 1'b0;
  int   m_pos = 0;
  int   m_cur = 0;

  // Expected outputs from position within the period and the period length.
  function automatic exp_t model_out(bit run, int pos, int cur, logic [1:0] sel);
    exp_t e;
    int sl, ph;
    e.sq = 1'b0; e.smp = 8'h00; e.ps = 1'b0;
    if (run) begin
      sl = cur / 256;
      if (sl == 0) sl = 1;
      ph = pos / sl;
      if (ph > 255) ph = 255;
      e.sq = (pos < cur / 2);
      e.ps = (pos == 0);
      case (sel)
        2'b01:   e.smp = 8'(ph);
        2'b10:   e.smp = (ph < 128) ? 8'(2 * ph) : 8'(511 - 2 * ph);
        default: e.smp = e.sq ? 8'hFF : 8'h00;
      endcase
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!nrst) m_run = 1'b0;
    else if (!m_run) begin
      if (bus.en && bus.divider > 16'd1) begin
        m_run = 1'b1; m_pos = 0; m_cur = int'(bus.divider);
      end
    end else if (!bus.en || bus.divider <= 16'd1) m_run = 1'b0;
    else if (m_pos == m_cur - 1) begin
      m_pos = 0; m_cur = int'(bus.divider);
    end else m_pos++;
    q.push_back(model_out(m_run, m_pos, m_cur, bus.wave_sel));
    #2;
  endtask

  task automatic drive(input logic en, input logic [15:0] div, input logic [1:0] sel);
    bus.en = en; bus.divider = div; bus.wave_sel = sel;
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (bus.square_out !== 1'b0 || bus.sample !== 8'h00 || bus.period_start !== 1'b0) begin
      fails++;
      $display("FAIL %s: got sq=%b smp=%h ps=%b, want all 0", name,
               bus.square_out, bus.sample, bus.period_start);
    end
  endtask

  // monitor: outputs are presented every cycle, compare each against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (bus.square_out !== e.sq || bus.sample !== e.smp || bus.period_start !== e.ps) begin
          fails++;
          $display("FAIL cycle@%0t: got sq=%b smp=%h ps=%b, want sq=%b smp=%h ps=%b", $time,
                   bus.square_out, bus.sample, bus.period_start, e.sq, e.smp, e.ps);
        end
      end
    end
  end

  initial begin
    drive(1'b0, 16'd0, 2'b00);
    #1 check_idle("reset_state");
    repeat (3) tick();
    nrst = 1'b1;

    drive(1'b1, 16'd10, 2'b00);
    repeat (35) tick();

    // asynchronous reset mid-run, held idle until re-enabled
    #2 nrst = 1'b0;
    #1 check_idle("async_reset");
    repeat (2) tick();
    drive(1'b0, 16'd10, 2'b00);
    nrst = 1'b1;
    repeat (3) tick();
    check_idle("idle_after_reset");
    drive(1'b1, 16'd10, 2'b00);
    repeat (12) tick();

    // long saw period: step_len 74, saturation at 255
    drive(1'b1, 16'd19111, 2'b01);
    repeat (19111 + 40) tick();

    drive(1'b1, 16'd11, 2'b10);
    repeat (40) tick();

    // divider change mid-period only applies at the wrap
    drive(1'b1, 16'd10, 2'b00);
    repeat (13) tick();
    bus.divider = 16'd20;
    repeat (50) tick();

    // mute paths
    bus.divider = 16'd1;
    repeat (3) tick();
    bus.divider = 16'd10;
    repeat (5) tick();
    bus.en = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 99) < 5) bus.en = ~bus.en;
      else if (!bus.en && $urandom_range(0, 9) == 0) bus.en = 1'b1;
      if ($urandom_range(0, 99) < 4) begin
        r = $urandom_range(0, 9);
        if (r == 0)      bus.divider = 16'($urandom_range(0, 1));
        else if (r < 7)  bus.divider = 16'($urandom_range(2, 40));
        else             bus.divider = 16'($urandom_range(256, 1500));
      end
      if ($urandom_range(0, 99) < 8) bus.wave_sel = 2'($urandom_range(0, 3));
      tick();
    end

    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
